ras_stack: RTL and testbench
============================

RAS_STACK -- requirements
Module: ras_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of stack entries; power of two, 2..64.
REQ-002 SHALL have parameter WIDTH, default 32, meaning return-address width in bits.
REQ-003 SHALL have parameter HIST, default 4, meaning maximum number of uncommitted speculative operations held for rollback; range 1..8.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port push  input  1  speculative push request (jal/jalr with rd=ra).
REQ-007 SHALL have port pop  input  1  speculative pop request (jalr return).
REQ-008 SHALL have port push_addr  input  WIDTH  address to push.
REQ-009 SHALL have port commit  input  1  retire the oldest uncommitted operation.
REQ-010 SHALL have port rollback  input  1  undo the youngest rollback_num uncommitted operations.
REQ-011 SHALL have port rollback_num  input  $clog2(HIST+1)  count of operations to undo.
REQ-012 SHALL have port top_addr  output  WIDTH  current top-of-stack address.
REQ-013 SHALL have port top_valid  output  1  stack non-empty.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  live entries.
REQ-015 SHALL have port hist_full  output  1  HIST uncommitted operations pending; caller holds push/pop.

Function
REQ-016 Storage SHALL be a circular buffer with tos pointer; top_addr and top_valid SHALL be combinational from registered state, so a push is visible the cycle after its edge.
REQ-017 push alone SHALL advance tos modulo DEPTH, write push_addr, and increment count saturating at DEPTH; at count==DEPTH the oldest entry is overwritten.
REQ-018 pop alone at count>0 SHALL retreat tos modulo DEPTH and decrement count; stack data is not cleared.
REQ-019 pop at count==0 SHALL leave tos and count unchanged and SHALL be recorded as a null operation.
REQ-020 push and pop in the same cycle SHALL replace the top entry with push_addr, leaving tos and count unchanged; at count==0 this is treated as a push.
REQ-021 Every accepted push, pop or replace SHALL append one history record: op type, tos and count before the op, and the overwritten slot data for push and replace.
REQ-022 push and pop SHALL be ignored, with no history record, while hist_full==1.
REQ-023 commit SHALL discard the oldest history record; commit with an empty history SHALL be ignored.
REQ-024 rollback SHALL, in one cycle, restore tos and count from the oldest undone record and rewrite the saved data of every undone push or replace, applied youngest first so the oldest record wins on a shared slot; undone records are removed.
REQ-025 rollback_num SHALL be clamped to the number of uncommitted records after same-cycle commit; rollback_num==0 SHALL be a no-op.
REQ-026 rollback SHALL have priority over push and pop: same-cycle push and pop are dropped.
REQ-027 commit and rollback in the same cycle SHALL apply the commit first, then the rollback to the remaining records.
REQ-028 hist_full SHALL equal (uncommitted records == HIST) and SHALL be registered state only.

Reset
REQ-029 On rst assertion, regardless of the clock, tos=0, count=0, history SHALL be empty, top_valid=0, hist_full=0, and top_addr=0; stack data is not required to reset.
REQ-030 Reset mid-operation SHALL discard all pending history; no rollback SHALL be possible across reset.

Structure
REQ-031 The op-type encoding (OP_NULL, OP_PUSH, OP_POP, OP_REPL) and the history-record struct SHALL live in shared package ras_pkg.
REQ-032 The history SHALL be a sub-module ras_hist: a HIST-deep FIFO with append, commit-pop-oldest, and drop-youngest-N, exposing all records to the parent.

Verification
REQ-033 Reset, push 0x100, 0x200, 0x300 -> top_addr=0x300, count=3; three pops -> count=0, top_valid=0; a fourth pop -> null record, count stays 0.
REQ-034 DEPTH=8: push 9 addresses 0x10..0x90 -> count=8, top_addr=0x90; eight pops return 0x90..0x20 in order, then top_valid=0.
REQ-035 Push 0xA, commit, then push 0xB and pop in the same cycle -> top_addr=0xB, count=1; rollback_num=1 -> top_addr=0xA, count=1.
REQ-036 Push 0x1, commit; pop, push 0x2, push 0x3 uncommitted; rollback_num=3 -> top_addr=0x1, count=1, history empty.
REQ-037 HIST=4: four uncommitted pushes -> hist_full=1; a fifth push is ignored (count=4); commit plus push in the same cycle -> hist_full=0 next cycle and count=4; push again -> accepted, count=5.
REQ-038 Rollback with a same-cycle push of 0xF -> push dropped; asserting rst asynchronously mid-sequence -> count=0 and hist_full=0 immediately.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack: op encoding and history record layout.
// Record fields are sized for the largest supported stack; users cast to their own widths.
package ras_pkg;

  typedef enum logic [1:0] {
    OP_NULL,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } op_e;

  localparam int unsigned MAX_PTR_W  = 6;
  localparam int unsigned MAX_CNT_W  = 7;
  localparam int unsigned MAX_ADDR_W = 64;

  typedef struct packed {
    op_e                   op;
    logic [MAX_PTR_W-1:0]  tos;
    logic [MAX_CNT_W-1:0]  cnt;
    logic [MAX_ADDR_W-1:0] data;
  } hist_rec_t;

endpackage

// File: rtl/ras_hist.sv
// Speculative-operation history FIFO, index 0 = oldest record.
// Supports append, commit (retire oldest) and drop of the youngest N records.
module ras_hist
  import ras_pkg::*;
#(
  parameter int unsigned HIST = 4,
  localparam int unsigned N_W = $clog2(HIST + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           append,
  input  hist_rec_t      append_rec,
  input  logic           commit,
  input  logic           drop,
  input  logic [N_W-1:0] drop_num,
  output hist_rec_t      recs [HIST],
  output logic [N_W-1:0] num,
  output logic [N_W-1:0] live,
  output logic           full
);

  hist_rec_t      recs_q [HIST];
  hist_rec_t      recs_d [HIST];
  logic [N_W-1:0] num_q, num_d;
  logic           full_q;
  logic           shift;

  assign shift = commit && (num_q != '0);
  // Records remaining once a same-cycle commit has been applied
  assign live  = num_q - N_W'(shift);

  always_comb begin
    recs_d = recs_q;
    if (shift) begin
      for (int i = 0; i < int'(HIST) - 1; i++) recs_d[i] = recs_q[i+1];
    end
    num_d = live;
    if (drop) begin
      num_d = live - drop_num;
    end else if (append) begin
      for (int i = 0; i < int'(HIST); i++) begin
        if (N_W'(i) == live) recs_d[i] = append_rec;
      end
      num_d = live + N_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q  <= '0;
      full_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      full_q <= (num_d == N_W'(HIST));
    end
  end

  always_ff @(posedge clk) begin
    recs_q <= recs_d;
  end

  assign recs = recs_q;
  assign num  = num_q;
  assign full = full_q;

endmodule

// File: rtl/ras_stack.sv
// Speculative return-address stack: circular buffer with per-op history so that
// uncommitted pushes/pops/replaces can be rolled back in a single cycle.
module ras_stack
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned HIST  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned N_W   = $clog2(HIST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             commit,
  input  logic             rollback,
  input  logic [N_W-1:0]   rollback_num,
  output logic [WIDTH-1:0] top_addr,
  output logic             top_valid,
  output logic [CNT_W-1:0] count,
  output logic             hist_full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hist_rec_t        hist_recs [HIST];
  hist_rec_t        sh [HIST];
  hist_rec_t        app_rec;
  logic             app;
  logic [N_W-1:0]   hist_num, live, rb_n, base;
  logic [PTR_W-1:0] slot;

  ras_hist #(
    .HIST(HIST)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .append    (app),
    .append_rec(app_rec),
    .commit    (commit),
    .drop      (rollback),
    .drop_num  (rb_n),
    .recs      (hist_recs),
    .num       (hist_num),
    .live      (live),
    .full      (hist_full)
  );

  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    app     = 1'b0;
    app_rec = '0;
    slot    = tos_q;
    base    = '0;
    rb_n    = (rollback_num > live) ? live : rollback_num;

    // History as seen after a same-cycle commit
    for (int i = 0; i < int'(HIST); i++) sh[i] = hist_recs[i];
    if (live != hist_num) begin
      for (int i = 0; i < int'(HIST) - 1; i++) sh[i] = hist_recs[i+1];
    end

    if (rollback) begin
      if (rb_n != '0) begin
        base = live - rb_n;
        for (int i = 0; i < int'(HIST); i++) begin
          if (N_W'(i) == base) begin
            tos_d = PTR_W'(sh[i].tos);
            cnt_d = CNT_W'(sh[i].cnt);
          end
        end
        // Youngest first so the oldest record's data survives on a shared slot
        for (int i = int'(HIST) - 1; i >= 0; i--) begin
          if (i >= int'(base) && i < int'(live)) begin
            if (sh[i].op == OP_PUSH) begin
              mem_d[PTR_W'(sh[i].tos) + PTR_W'(1)] = WIDTH'(sh[i].data);
            end else if (sh[i].op == OP_REPL) begin
              mem_d[PTR_W'(sh[i].tos)] = WIDTH'(sh[i].data);
            end
          end
        end
      end
    end else if (!hist_full && (push || pop)) begin
      app         = 1'b1;
      app_rec.tos = MAX_PTR_W'(tos_q);
      app_rec.cnt = MAX_CNT_W'(cnt_q);
      if (push && (!pop || cnt_q == '0)) begin
        slot         = tos_q + PTR_W'(1);
        app_rec.op   = OP_PUSH;
        tos_d        = slot;
        cnt_d        = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
        mem_d[slot]  = push_addr;
      end else if (push) begin
        app_rec.op   = OP_REPL;
        mem_d[slot]  = push_addr;
      end else if (cnt_q != '0) begin
        app_rec.op   = OP_POP;
        tos_d        = tos_q - PTR_W'(1);
        cnt_d        = cnt_q - CNT_W'(1);
      end else begin
        app_rec.op   = OP_NULL;
      end
      app_rec.data = MAX_ADDR_W'(mem_q[slot]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_valid = (cnt_q != '0);
  assign top_addr  = top_valid ? mem_q[tos_q] : '0;
  assign count     = cnt_q;

endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack (DEPTH=8, WIDTH=32, HIST=4) with hand-computed expectations.
module tb_ras_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, commit, rollback;
  logic [31:0] push_addr;
  logic [2:0]  rollback_num;
  logic [31:0] top_addr;
  logic        top_valid;
  logic [3:0]  count;
  logic        hist_full;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ras_stack #(
    .DEPTH(8),
    .WIDTH(32),
    .HIST (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_addr   (push_addr),
    .commit      (commit),
    .rollback    (rollback),
    .rollback_num(rollback_num),
    .top_addr    (top_addr),
    .top_valid   (top_valid),
    .count       (count),
    .hist_full   (hist_full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic po, input logic [31:0] a, input logic c,
                     input logic rb, input logic [2:0] rn);
    push = p; pop = po; push_addr = a; commit = c; rollback = rb; rollback_num = rn;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; push_addr = '0; commit = 1'b0; rollback = 1'b0;
    rollback_num = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    push = 0; pop = 0; push_addr = 0; commit = 0; rollback = 0; rollback_num = 0;
    rst = 1'b1;
    #3;
    check_eq("rst_valid", {31'b0, top_valid}, 32'd0);
    check_eq("rst_count", {28'b0, count}, 32'd0);
    check_eq("rst_full", {31'b0, hist_full}, 32'd0);
    check_eq("rst_top", top_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic push/pop with null pop at empty
    cyc(1, 0, 32'h100, 1, 0, 0);
    cyc(1, 0, 32'h200, 1, 0, 0);
    cyc(1, 0, 32'h300, 1, 0, 0);
    check_eq("b_top", top_addr, 32'h300);
    check_eq("b_count", {28'b0, count}, 32'd3);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, 0, 0);
    check_eq("b_count0", {28'b0, count}, 32'd0);
    check_eq("b_valid0", {31'b0, top_valid}, 32'd0);
    cyc(0, 1, 0, 1, 0, 0);
    check_eq("b_nullpop", {28'b0, count}, 32'd0);

    // Wrap-around overwrite of the oldest entry
    do_reset();
    for (int k = 1; k <= 9; k++) cyc(1, 0, 32'(k * 16), 1, 0, 0);
    check_eq("w_count", {28'b0, count}, 32'd8);
    check_eq("w_top", top_addr, 32'h90);
    for (int k = 0; k < 8; k++) begin
      check_eq("w_popseq", top_addr, 32'(32'h90 - k * 16));
      cyc(0, 1, 0, 1, 0, 0);
    end
    check_eq("w_valid0", {31'b0, top_valid}, 32'd0);

    // Replace then rollback
    do_reset();
    cyc(1, 0, 32'hA, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'hB, 0, 0, 0);
    check_eq("r_top", top_addr, 32'hB);
    check_eq("r_count", {28'b0, count}, 32'd1);
    cyc(0, 0, 0, 0, 1, 3'd1);
    check_eq("r_rb_top", top_addr, 32'hA);
    check_eq("r_rb_count", {28'b0, count}, 32'd1);

    // Multi-record rollback restoring a popped entry
    do_reset();
    cyc(1, 0, 32'h1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 32'h2, 0, 0, 0);
    cyc(1, 0, 32'h3, 0, 0, 0);
    check_eq("m_pre_count", {28'b0, count}, 32'd2);
    check_eq("m_pre_top", top_addr, 32'h3);
    cyc(0, 0, 0, 0, 1, 3'd3);
    check_eq("m_top", top_addr, 32'h1);
    check_eq("m_count", {28'b0, count}, 32'd1);
    check_eq("m_full", {31'b0, hist_full}, 32'd0);

    // History full behaviour
    do_reset();
    cyc(1, 0, 32'h11, 0, 0, 0);
    cyc(1, 0, 32'h22, 0, 0, 0);
    cyc(1, 0, 32'h33, 0, 0, 0);
    cyc(1, 0, 32'h44, 0, 0, 0);
    check_eq("f_full", {31'b0, hist_full}, 32'd1);
    check_eq("f_count4", {28'b0, count}, 32'd4);
    cyc(1, 0, 32'h55, 0, 0, 0);
    check_eq("f_ign_count", {28'b0, count}, 32'd4);
    check_eq("f_ign_top", top_addr, 32'h44);
    cyc(1, 0, 32'h66, 1, 0, 0);
    check_eq("f_cm_full", {31'b0, hist_full}, 32'd0);
    check_eq("f_cm_count", {28'b0, count}, 32'd4);
    cyc(1, 0, 32'h77, 0, 0, 0);
    check_eq("f_acc_count", {28'b0, count}, 32'd5);
    check_eq("f_acc_top", top_addr, 32'h77);
    check_eq("f_acc_full", {31'b0, hist_full}, 32'd1);

    // Rollback drops a same-cycle push
    cyc(1, 0, 32'hF, 0, 1, 3'd2);
    check_eq("p_count", {28'b0, count}, 32'd3);
    check_eq("p_top", top_addr, 32'h33);
    check_eq("p_full", {31'b0, hist_full}, 32'd0);

    // Asynchronous reset mid-sequence
    cyc(1, 0, 32'h88, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("a_count", {28'b0, count}, 32'd0);
    check_eq("a_full", {31'b0, hist_full}, 32'd0);
    check_eq("a_valid", {31'b0, top_valid}, 32'd0);
    check_eq("a_top", top_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 1, 3'd4);
    check_eq("a_norb_count", {28'b0, count}, 32'd0);
    check_eq("a_norb_valid", {31'b0, top_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
